// File: rtl/m2_mem_pkg.sv
// Shared constants and types for the M2 ping-pong telemetry memory write path.
package m2_mem_pkg;

  localparam int unsigned M2_DEPTH = 256;
  localparam int unsigned M2_DW    = 12;
  localparam int unsigned M2_AW    = 8;
  localparam int unsigned M2_CW    = M2_AW + 1;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/m2_rr_arbiter.sv
// Request arbiter for the M2 bank writer: round-robin by default, fixed
// lowest-index priority when M2BW_PRIORITY_EN is defined.
module m2_rr_arbiter #(
  parameter int unsigned NCH = 4,
  localparam int unsigned IW = $clog2(NCH)
) (
`ifndef M2BW_PRIORITY_EN
  input  logic           clk,
  input  logic           reset,
`endif
  input  logic           en,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] mask,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           valid
);

  logic [NCH-1:0] cand;
  logic           found;

  // A source whose ack is still in flight must not win again.
  assign cand  = req & ~mask;
  assign valid = en & found;

  always_comb begin
    gnt = '0;
    if (valid) gnt[idx] = 1'b1;
  end

`ifdef M2BW_PRIORITY_EN

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

`else

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cur;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] v);
    return (v == IW'(NCH - 1)) ? '0 : v + 1'b1;
  endfunction

  // Scan all channels starting at rr_ptr, wrapping modulo NCH.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cur   = rr_ptr;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && cand[cur]) begin
        found = 1'b1;
        idx   = cur;
      end
      cur = next_idx(cur);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (valid) begin
      rr_ptr <= next_idx(idx);
    end
  end

`endif

endmodule

// File: rtl/m2_bank_writer.sv
// Write-side controller for the M2 ping-pong telemetry memory: fills the bank
// the generator is not reading. Optional macro: M2BW_PRIORITY_EN.
module m2_bank_writer
  import m2_mem_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = M2_DEPTH,
  parameter int unsigned DW    = M2_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSwitch,
  input  logic [NCH-1:0]    iReq,
  input  logic [NCH*DW-1:0] iData,
  output logic [NCH-1:0]    oAck,
  output logic              oWrEn,
  output logic [M2_CW-1:0]  oWrAddr,
  output logic [DW-1:0]     oWrData,
  output logic              oFull,
  output logic              oOverrun,
  output logic              oUnderrun,
  output logic [M2_CW-1:0]  oFillCnt
);

  localparam int unsigned IW = $clog2(NCH);

  wr_state_e        state;
  logic             wr_bank;
  logic             sw_prev;
  logic [M2_CW-1:0] ptr;
  logic             swap;
  logic             arb_en;
  logic [NCH-1:0]   gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_valid;

  assign swap     = iSwitch ^ sw_prev;
  assign arb_en   = (state == FILL) && !swap;
  assign oFillCnt = ptr;

  // oAck is exactly the previous cycle's grant, so it doubles as the mask.
  m2_rr_arbiter #(.NCH(NCH)) u_arb (
`ifndef M2BW_PRIORITY_EN
    .clk   (clk),
    .reset (reset),
`endif
    .en    (arb_en),
    .req   (iReq),
    .mask  (oAck),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      wr_bank   <= BANK1;
      sw_prev   <= 1'b0;
      ptr       <= '0;
      oAck      <= '0;
      oWrEn     <= 1'b0;
      oWrAddr   <= '0;
      oWrData   <= '0;
      oFull     <= 1'b0;
      oOverrun  <= 1'b0;
      oUnderrun <= 1'b0;
    end else begin
      sw_prev <= iSwitch;
      oAck    <= '0;
      oWrEn   <= 1'b0;
      if (swap) begin
        // Generator changed banks: restart the fill in the bank it just left.
        state   <= FILL;
        ptr     <= '0;
        wr_bank <= ~iSwitch;
        oFull   <= 1'b0;
        if (ptr != M2_CW'(DEPTH)) oUnderrun <= 1'b1;
      end else if (state == FILL) begin
        if (gnt_valid) begin
          oAck    <= gnt;
          oWrEn   <= 1'b1;
          oWrAddr <= {wr_bank, ptr[M2_AW-1:0]};
          oWrData <= iData[gnt_idx*DW +: DW];
          ptr     <= ptr + 1'b1;
          if (ptr == M2_CW'(DEPTH - 1)) begin
            state <= FULL;
            oFull <= 1'b1;
          end
        end
      end else begin
        if (|iReq) oOverrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m2_bank_writer.sv
// Self-checking bench for m2_bank_writer: fixed vectors, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_m2_bank_writer;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 256;
`ifdef M2BW_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              sw;
  logic [NCH-1:0]    req;
  logic [DW-1:0]     dat [NCH];
  logic [NCH*DW-1:0] idata;
  logic [NCH-1:0]    oAck;
  logic              oWrEn;
  logic [8:0]        oWrAddr;
  logic [DW-1:0]     oWrData;
  logic              oFull;
  logic              oOverrun;
  logic              oUnderrun;
  logic [8:0]        oFillCnt;

  m2_bank_writer #(.NCH(NCH), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .iSwitch   (sw),
    .iReq      (req),
    .iData     (idata),
    .oAck      (oAck),
    .oWrEn     (oWrEn),
    .oWrAddr   (oWrAddr),
    .oWrData   (oWrData),
    .oFull     (oFull),
    .oOverrun  (oOverrun),
    .oUnderrun (oUnderrun),
    .oFillCnt  (oFillCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NCH; k++) idata[k*DW +: DW] = dat[k];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: words written so far, which bank, who won last cycle.
  int             m_ptr;
  int             m_bank;
  int             m_prev;
  int             m_rr;
  bit             m_sw_prev;
  bit             e_wren;
  logic [NCH-1:0] e_ack;
  int             e_addr;
  int             e_data;
  bit             e_ovr;
  bit             e_und;

  task automatic model_reset();
    m_ptr = 0; m_bank = 1; m_prev = -1; m_rr = 0; m_sw_prev = 1'b0;
    e_wren = 1'b0; e_ack = '0; e_ovr = 1'b0; e_und = 1'b0;
  endtask

  task automatic model_eval();
    int g;
    bit swp;
    swp = sw ^ m_sw_prev;
    m_sw_prev = sw;
    e_wren = 1'b0;
    e_ack = '0;
    if (swp) begin
      if (m_ptr != DEPTH) e_und = 1'b1;
      m_ptr = 0;
      m_bank = sw ? 0 : 1;
      m_prev = -1;
    end else if (m_ptr < DEPTH) begin
      g = -1;
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = PRIO ? i : (m_rr + i) % NCH;
        if (g < 0 && req[c] && c != m_prev) g = c;
      end
      if (g >= 0) begin
        e_wren = 1'b1;
        e_ack[g] = 1'b1;
        e_addr = m_bank * 256 + m_ptr;
        e_data = int'(dat[g]);
        m_ptr++;
        m_rr = (g + 1) % NCH;
      end
      m_prev = g;
    end else begin
      if (req != '0) e_ovr = 1'b1;
      m_prev = -1;
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    chk("wren", oWrEn, e_wren);
    chk("ack", oAck, e_ack);
    if (e_wren) begin
      chk("addr", oWrAddr, e_addr);
      chk("data", oWrData, e_data);
    end
    chk("full", oFull, (m_ptr == DEPTH));
    chk("fillcnt", oFillCnt, m_ptr);
    chk("overrun", oOverrun, e_ovr);
    chk("underrun", oUnderrun, e_und);
  endtask

  // Sources hold request and data until acked, then follow 'want'.
  task automatic refresh(input logic [NCH-1:0] want, input bit rnd, input logic [DW-1:0] fixed);
    for (int k = 0; k < NCH; k++) begin
      if (e_ack[k] || !req[k]) begin
        req[k] = want[k];
        dat[k] = rnd ? DW'($urandom) : fixed;
      end
    end
  endtask

  task automatic refresh_rand();
    for (int k = 0; k < NCH; k++) begin
      if (e_ack[k] || !req[k]) begin
        req[k] = ($urandom_range(0, 3) != 0);
        dat[k] = DW'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    chk("rst_wren", oWrEn, 0);
    chk("rst_ack", oAck, 0);
    chk("rst_fill", oFillCnt, 0);
    chk("rst_flags", {oFull, oOverrun, oUnderrun}, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [NCH-1:0] req;
    logic [DW-1:0]  d0;
    logic [DW-1:0]  d1;
    bit             wren;
    logic [NCH-1:0] ack;
    logic [8:0]     addr;
    logic [DW-1:0]  data;
    logic [8:0]     fill;
  } vec_t;

  vec_t vt [6];
  int   cnt [NCH];
  int   nacc;

  initial begin
    reset = 1'b0; sw = 1'b0; req = '0;
    for (int k = 0; k < NCH; k++) dat[k] = '0;
    model_reset();

    // Fixed vectors straight out of reset (write bank 1).
    vt[0] = '{4'b0001, 12'hA5A, 12'h000, 1'b1, 4'b0001, 9'h100, 12'hA5A, 9'd1};
    vt[1] = '{4'b0001, 12'hA5A, 12'h000, 1'b0, 4'b0000, 9'h000, 12'h000, 9'd1};
    vt[2] = '{4'b0001, 12'h123, 12'h000, 1'b1, 4'b0001, 9'h101, 12'h123, 9'd2};
    vt[3] = '{4'b0011, 12'h123, 12'h456, 1'b1, 4'b0010, 9'h102, 12'h456, 9'd3};
    vt[4] = '{4'b0011, 12'h789, 12'h456, 1'b1, 4'b0001, 9'h103, 12'h789, 9'd4};
    vt[5] = '{4'b0000, 12'h000, 12'h000, 1'b0, 4'b0000, 9'h000, 12'h000, 9'd4};
    do_reset();
    for (int v = 0; v < 6; v++) begin
      req = vt[v].req; dat[0] = vt[v].d0; dat[1] = vt[v].d1;
      step();
      chk($sformatf("vec%0d_wren", v), oWrEn, vt[v].wren);
      chk($sformatf("vec%0d_ack", v), oAck, vt[v].ack);
      if (vt[v].wren) begin
        chk($sformatf("vec%0d_addr", v), oWrAddr, vt[v].addr);
        chk($sformatf("vec%0d_data", v), oWrData, vt[v].data);
      end
      chk($sformatf("vec%0d_fill", v), oFillCnt, vt[v].fill);
    end

    // Single requester: one word every other cycle until the bank is full.
    do_reset();
    req = 4'b0001; dat[0] = 12'hA5A; nacc = 0;
    for (int n = 0; n < 511; n++) begin
      step();
      if (oAck[0]) nacc++;
      refresh(4'b0001, 1'b0, 12'hA5A);
    end
    chk("single_acks", nacc, 256);
    chk("single_full", oFull, 1);
    chk("single_fill", oFillCnt, 256);

    // Requests while full: no writes, sticky overrun.
    refresh(4'b0010, 1'b0, 12'h0F0);
    nacc = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (oWrEn || oAck != '0) nacc++;
    end
    chk("full_no_write", nacc, 0);
    chk("full_overrun", oOverrun, 1);

    // All four requesting: one write per cycle.
    do_reset();
    req = '1;
    for (int k = 0; k < NCH; k++) begin dat[k] = DW'($urandom); cnt[k] = 0; end
    nacc = 0;
    for (int n = 0; n < 256; n++) begin
      step();
      if (oWrEn) nacc++;
      for (int k = 0; k < NCH; k++) if (oAck[k]) cnt[k]++;
      refresh('1, 1'b1, '0);
    end
    chk("all_writes", nacc, 256);
    chk("all_full", oFull, 1);
    for (int k = 0; k < NCH; k++)
      chk($sformatf("all_ch%0d", k), cnt[k], PRIO ? ((k < 2) ? 128 : 0) : 64);

    // Bank swap after 100 writes: underrun and restart at 9'h000.
    do_reset();
    req = '1;
    for (int n = 0; n < 100; n++) begin
      step();
      refresh('1, 1'b1, '0);
    end
    chk("pre_swap_fill", oFillCnt, 100);
    sw = 1'b1;
    step();
    chk("swap_wren", oWrEn, 0);
    chk("swap_underrun", oUnderrun, 1);
    chk("swap_fill", oFillCnt, 0);
    refresh('1, 1'b1, '0);
    step();
    chk("post_swap_addr", oWrAddr, 9'h000);
    chk("post_swap_fill", oFillCnt, 1);

    // Swap coinciding with a fresh request: grant deferred to the new bank.
    sw = 1'b0;
    do_reset();
    req = 4'b0001; dat[0] = 12'h3C3; sw = 1'b1;
    step();
    chk("swapreq_noack", oAck, 0);
    step();
    chk("swapreq_ack", oAck, 4'b0001);
    chk("swapreq_addr", oWrAddr, 9'h000);

    // Reset lands while an ack is due: it is lost and the source re-requests.
    sw = 1'b0;
    do_reset();
    req = 4'b0001; dat[0] = 12'h111;
    step();
    refresh(4'b0001, 1'b0, 12'h222);
    step();
    refresh(4'b0001, 1'b0, 12'h222);
    #4;
    reset = 1'b0;
    #1;
    chk("midrst_fill", oFillCnt, 0);
    @(posedge clk);
    #1;
    chk("midrst_ack", oAck, 0);
    chk("midrst_wren", oWrEn, 0);
    chk("midrst_fill2", oFillCnt, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step();
    chk("midrst_addr", oWrAddr, 9'h100);
    chk("midrst_data", oWrData, 12'h222);

    // Randomized traffic with occasional bank swaps.
    do_reset();
    req = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) sw = ~sw;
      step();
      refresh_rand();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m2_bank_writer.md
Name: m2_bank_writer

Overview:
Write-side controller for the M2 ping-pong telemetry memory (2 banks x 256 words x 12 bit).
- Arbitrates up to NCH sample sources and writes their words sequentially into the bank the frame generator is not reading.
- Tracks the generator's bank-select toggle to restart each fill.
- Reports fill level, overrun and underrun.

Parameters:
NCH, 4, number of requesting sources (2..8)
DEPTH, 256, words per bank; must match generator address space (8-bit address)
DW, 12, data word width

Ports:
clk  in  1  system clock, same domain as frame generator (2 x 12.582912 MHz)
reset  in  1  asynchronous, active-low
iSwitch  in  1  generator bank select; generator reads bank iSwitch
iReq  in  NCH  per-source write request; held with data until acked
iData  in  NCH*DW  per-source word, source k at bits [k*DW +: DW]
oAck  out  NCH  one-cycle pulse, word from source k accepted
oWrEn  out  1  memory write strobe
oWrAddr  out  9  {bank, word address[7:0]}
oWrData  out  DW  word to write
oFull  out  1  current write bank completely filled
oOverrun  out  1  sticky: request pending while FULL
oUnderrun  out  1  sticky: bank swap before current bank filled
oFillCnt  out  9  words written into current bank (0..256)

Behaviour:
- Reset values: all outputs 0; internal wrBank=1 (opposite of generator reset bank 0); ptr=0; swPrev=0; rrPtr=0; state FILL.
- Swap detect: swPrev registers iSwitch each cycle; swap = iSwitch ^ swPrev.
- States:
  - FILL: arbitrate; on grant, ptr increments; ptr reaching DEPTH -> FULL.
  - FULL: no grants; any iReq bit high sets oOverrun.
  - Any state + swap -> FILL.
- Swap cycle (highest priority):
  - no grant; ptr<=0; wrBank<=~iSwitch; oFull<=0.
  - If ptr!=DEPTH at the swap, set oUnderrun.
- Grant, FILL state, no swap:
  - Candidate set = iReq masked by the channel granted in the previous cycle, so a source whose ack is still in flight is not re-granted.
  - Round-robin from rrPtr; after a grant, rrPtr = granted index + 1 (mod NCH).
- Registered outputs, one cycle after the grant decision:
  - oWrEn=1
  - oWrAddr={wrBank, ptr[7:0]}
  - oWrData=iData of granted source
  - oAck[g]=1
  - otherwise oWrEn=0 and oAck=0; oWrAddr/oWrData hold their last values.
- Throughput: one write per cycle with two or more requesters; one write per 2 cycles with a single requester.
- oFillCnt = ptr, 9 bits, saturates at DEPTH. oFull=1 exactly while ptr==DEPTH.
- Sticky flags clear only on reset.
- Reset mid-fill: all state returns to reset values immediately (async); a pending ack is lost and the source must re-request.
- Unused bank bit wrap-around: ptr never exceeds DEPTH; address 255 is the last write of a bank.

Optional Feature:
M2BW_PRIORITY_EN
- Defined: fixed priority, lowest index wins; rrPtr is unused. The previous-grant mask still applies.
- Undefined: round-robin as above.

Decomposition:
- Package m2_mem_pkg:
  - DEPTH, DW and address width constants.
  - Bank encoding constants (BANK0=0, BANK1=1).
  - State enum {FILL, FULL}.
- One natural sub-module: m2_rr_arbiter (NCH-wide request/mask in, one-hot grant plus index out, rrPtr internal), covering both arbitration modes under the macro.

Test Plan:
- Reset, then iReq=0001 held with data 12'hA5A: acks every 2nd cycle. Writes at addresses 9'h100, 9'h101, ... with data A5A. oFillCnt counts to 256, then oFull=1.
- iReq=1111 continuously: grants follow the order 0,1,2,3,0...; write every cycle. Without the macro, 64 writes per channel to fill. With M2BW_PRIORITY_EN: mask alternates grants between ch0 and ch1.
- Fill to 256, keep iReq=0010: no further writes or acks; oOverrun=1.
- Toggle iSwitch 1->... (to 1) after 100 writes: oUnderrun=1. Next write goes to 9'h000; oFillCnt restarts 0->1.
- Swap in the same cycle as a pending request: no ack in the following cycle; first write of the new bank lands at ptr 0.
- Assert reset while oAck pulse is due: oAck=0, oWrEn=0, oFillCnt=0. wrBank returns to 1 and the first post-reset write goes to 9'h100.
